// File: rtl/pll_dps_step_ctrl.sv
// Dynamic-phase-shift sequencer: walks the PLL output phase one step at a time, handshaking on phase_done.
// Optional phase-position tracking is built when PLL_DPS_POS_TRACK_EN is defined.
`timescale 1ns/1ps
module pll_dps_step_ctrl #(
  parameter int STEP_W          = 8,
  parameter int PHASE_EN_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int GAP_CYCLES      = 2,
  parameter int POS_MOD         = 24
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_updn,
  input  logic [4:0]        cmd_cntsel,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  input  logic              phase_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [STEP_W-1:0] steps_left,
  output logic [7:0]        phase_pos,
  output logic [2:0]        dbg_state
);

  localparam int CNT_MAX_A = (TIMEOUT_CYCLES > PHASE_EN_CYCLES) ? TIMEOUT_CYCLES : PHASE_EN_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  if (PHASE_EN_CYCLES < 1 || POS_MOD < 1 || POS_MOD > 256) begin : g_bad_param
    $error("pll_dps_step_ctrl: PHASE_EN_CYCLES must be >= 1 and POS_MOD within 1..256");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pd_s1_q, pd_s2_q, lo_seen_q;
  logic               phase_en_q, phase_en_d, busy_q, busy_d, done_q, done_d;
  logic               updn_q, updn_d, err_q, err_d;
  logic [4:0]         cntsel_q, cntsel_d;
  logic [1:0]         err_code_q, err_code_d, fail_code;
  logic [STEP_W-1:0]  steps_left_q, steps_left_d;
  logic               accept, step_done, lock_watch;

  // Command handshake: a command transfers on a refclk edge where cmd_valid and cmd_ready are both high;
  // cmd_ready is combinational and drops as soon as the sequencer leaves IDLE, so nothing is queued.
  assign cmd_ready  = (state_q == S_IDLE) & pll_locked & rst_n;
  assign accept     = cmd_valid & cmd_ready;
  assign lock_watch = (state_q == S_PULSE) || (state_q == S_WAIT_LO) ||
                      (state_q == S_WAIT_HI) || (state_q == S_GAP);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fail_code = 2'd0;
    step_done = 1'b0;
    case (state_q)
      // A zero-step command passes through ERR with no cause so done lands one cycle after busy.
      S_IDLE:    if (accept) state_d = (cmd_steps == '0) ? S_ERR : S_PULSE;
      S_PULSE:   if (cnt_q == CNT_W'(PHASE_EN_CYCLES - 1)) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (lo_seen_q || !pd_s2_q) state_d = S_WAIT_HI;
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_ERR;
          fail_code = 2'd1;
        end
      end
      S_WAIT_HI: begin
        if (pd_s2_q) begin
          step_done = 1'b1;
          if (steps_left_q == STEP_W'(1)) state_d = S_DONE;
          else                            state_d = (GAP_CYCLES == 0) ? S_PULSE : S_GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_ERR;
          fail_code = 2'd2;
        end
      end
      S_GAP:     if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = S_PULSE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (lock_watch && !pll_locked) begin
      state_d   = S_ERR;
      fail_code = 2'd3;
      step_done = 1'b0;
    end
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else                                         cnt_d = cnt_q + CNT_W'(1);
  end

`ifdef PLL_DPS_POS_TRACK_EN
  logic [7:0] pos_q, pos_d;
`endif

  always_comb begin
    phase_en_d   = (state_d == S_PULSE);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    updn_d       = updn_q;
    cntsel_d     = cntsel_q;
    steps_left_d = steps_left_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    if (accept) begin
      updn_d       = cmd_updn;
      cntsel_d     = cmd_cntsel;
      steps_left_d = cmd_steps;
      err_d        = 1'b0;
      err_code_d   = 2'd0;
    end
    if (step_done) steps_left_d = steps_left_q - STEP_W'(1);
    if (fail_code != 2'd0) begin
      err_d      = 1'b1;
      err_code_d = fail_code;
    end
`ifdef PLL_DPS_POS_TRACK_EN
    pos_d = pos_q;
    if (step_done && cntsel_q == 5'd0) begin
      if (updn_q) pos_d = (pos_q == 8'(POS_MOD - 1)) ? 8'd0 : pos_q + 8'd1;
      else        pos_d = (pos_q == 8'd0) ? 8'(POS_MOD - 1) : pos_q - 8'd1;
    end
`endif
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      pd_s1_q      <= 1'b1;
      pd_s2_q      <= 1'b1;
      lo_seen_q    <= 1'b0;
      phase_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      updn_q       <= 1'b0;
      cntsel_q     <= 5'd0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      steps_left_q <= '0;
`ifdef PLL_DPS_POS_TRACK_EN
      pos_q        <= 8'd0;
`endif
    end else begin
      pd_s1_q      <= phase_done;
      pd_s2_q      <= pd_s1_q;
      // A phase_done low already observed while phase_en is high satisfies WAIT_LO.
      if (state_q != S_PULSE && state_d == S_PULSE) lo_seen_q <= 1'b0;
      else if (state_q == S_PULSE && !pd_s2_q)      lo_seen_q <= 1'b1;
      phase_en_q   <= phase_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      updn_q       <= updn_d;
      cntsel_q     <= cntsel_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      steps_left_q <= steps_left_d;
`ifdef PLL_DPS_POS_TRACK_EN
      pos_q        <= pos_d;
`endif
    end
  end

  assign phase_en   = phase_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign updn       = updn_q;
  assign cntsel     = cntsel_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign steps_left = steps_left_q;
  assign dbg_state  = state_q;
`ifdef PLL_DPS_POS_TRACK_EN
  assign phase_pos  = pos_q;
`else
  assign phase_pos  = 8'd0;
`endif

endmodule

// File: doc/pll_dps_step_ctrl.md
Name: pll_dps_step_ctrl

Overview:
- Dynamic-phase-shift sequencer for the AD9653 sample-clock PLL.
- Accepts a "shift N steps up/down on counter K" command and drives the PLL's phase_en/updn/cntsel port one step at a time, handshaking on phase_done.
- Tracks completion, timeouts and lock loss; used by the ADC data-eye training logic to walk the output clock phase.

Parameters:
STEP_W, 8, width of the step-count field (max steps per command = 2^STEP_W-1)
PHASE_EN_CYCLES, 2, clock cycles phase_en is held high per step (must be >= 1)
TIMEOUT_CYCLES, 1023, max cycles waiting for each phase_done edge before error
GAP_CYCLES, 2, idle cycles inserted between consecutive steps
POS_MOD, 24, phase steps per output-clock period (VCO/8 granularity x C divide 3)

Ports:
refclk  in  1  PLL reference / controller clock (100 MHz)
rst_n  in  1  synchronous reset, active-low
pll_locked  in  1  PLL locked indicator
cmd_valid  in  1  command request
cmd_ready  out  1  command can be accepted
cmd_steps  in  STEP_W  number of phase steps
cmd_updn  in  1  1 = shift later (up), 0 = earlier (down)
cmd_cntsel  in  5  PLL counter select (0 = C0)
phase_en  out  1  to PLL phase_en
updn  out  1  to PLL updn
cntsel  out  5  to PLL cntsel
phase_done  in  1  from PLL; driven low by PLL while a step is in progress
busy  out  1  command in progress
done  out  1  one-cycle pulse: command finished, OK or error
err  out  1  sticky error flag, cleared on next accepted command
err_code  out  2  0 none, 1 timeout on phase_done low, 2 timeout on phase_done high, 3 lock lost
steps_left  out  STEP_W  remaining steps of current command
phase_pos  out  8  net phase position modulo POS_MOD (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a refclk edge): state IDLE; all outputs 0, except cmd_ready (follows its IDLE rule after reset). Reset mid-step drops phase_en on the next edge; no done pulse is issued.
- Registered outputs, with one exception: cmd_ready = (state==IDLE) & pll_locked & rst_n.
- Accept: cmd_valid & cmd_ready at an edge latches steps/updn/cntsel. updn and cntsel are held stable from that edge until return to IDLE. busy=1 from the next cycle. err and err_code are cleared on acceptance.
- cmd_steps=0: go to DONE directly; done pulses 2 cycles after acceptance; phase_en never asserted.
- FSM:
  - IDLE: wait for accept.
  - PULSE: phase_en=1 for exactly PHASE_EN_CYCLES cycles, then go to WAIT_LO.
  - WAIT_LO: wait for phase_done=0. A low seen already during PULSE counts.
  - WAIT_HI: wait for phase_done=1. On rising: steps_left decrements, phase_pos updates; go to GAP if steps_left becomes nonzero, else DONE.
  - GAP: GAP_CYCLES idle cycles, then PULSE.
  - DONE: done=1 for one cycle, busy=0 the same cycle, then IDLE.
  - ERR: set err and err_code, then go to DONE.
- Timeout: a single counter, reset on entry to WAIT_LO and WAIT_HI. Reaching TIMEOUT_CYCLES goes to ERR with code 1 or 2; phase_en=0.
- Lock loss: pll_locked=0 in any state other than IDLE/DONE goes to ERR (code 3) on the next edge. Lock loss has priority over a timeout in the same cycle. phase_en is deasserted in that cycle's register update. Remaining steps are discarded; steps_left keeps its value for debug.
- phase_done is synchronised internally with 2 flops. This synchroniser latency is included in the WAIT_LO/WAIT_HI cycle counts.
- Commands presented while busy are not accepted (cmd_ready=0). No queuing.

Optional Feature:
PLL_DPS_POS_TRACK_EN
- Defined: phase_pos steps +1 (updn=1) or -1 (updn=0) per completed step, modulo POS_MOD. Wrap is POS_MOD-1 -> 0 going up and 0 -> POS_MOD-1 going down. phase_pos is valid only for cntsel=0 and is not updated for other counters. Reset value 0.
- Not defined: phase_pos is tied to 0 and no tracking logic is built.

Test Plan:
- Lock high, cmd steps=3 updn=1 cntsel=0, PLL model lowers phase_done 2 cycles after phase_en rises and raises it 4 cycles later -> exactly 3 phase_en pulses, each 2 cycles wide, 2-cycle gaps; updn=1 and cntsel=0 stable throughout; one done pulse with err=0; steps_left=0; phase_pos=3 (macro on).
- steps=0 -> done 2 cycles after accept; phase_en never high; err=0.
- Model never lowers phase_done -> err=1, err_code=1 after 1023 cycles in WAIT_LO; single done pulse; phase_en=0.
- pll_locked dropped during the 2nd step of a 5-step command -> err_code=3 within 1 cycle; phase_en=0; steps_left=4; done pulses; cmd_ready stays 0 until lock returns.
- Macro on, phase_pos=1, cmd steps=3 updn=0 -> phase_pos=22 (wrap 1->0->23->22); then a steps=2 updn=1 command -> phase_pos=0 (23->0 wrap).
- rst_n asserted mid-WAIT_HI -> next edge: busy=0, phase_en=0, no done pulse; a new command is accepted normally once rst_n=1 and lock is high.
